adc_serial_responder: RTL

Synthesizable model of the serial ADC that answers the tag's detector read port: it watches the chip-select and serial clock driven by the detector front end and shifts a parallel sample out on the serial data line, MSB first, behind a fixed run of leading zeros. It sits in the loctag bench and self-test builds, standing in for the physical converter. It allows known envelope samples to be fed into the detector path on the FPGA itself.

---
 rtl/adc_serial_pkg.sv | 20 ++
 rtl/edge_sync.sv | 30 +++
 rtl/adc_serial_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/adc_serial_pkg.sv
// Shared types and sizing helpers for the serial ADC responder.
package adc_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL
    } state_e;

    function automatic int unsigned frame_len(input int unsigned data_bits,
                                              input int unsigned lead_zeros);
        return data_bits + lead_zeros;
    endfunction

    // Bit counter must be able to hold the value F itself (terminal count).
    function automatic int unsigned idx_width(input int unsigned frame_bits);
        return unsigned'($clog2(frame_bits + 1));
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall detect on the synced level.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Decoded from flops only, so the consumer sees the edge one cycle after the last stage.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Serial ADC stand-in: shifts a held sample out MSB first behind a run of lead zeros.
module adc_serial_responder
    import adc_serial_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 12,
    parameter int unsigned LEAD_ZEROS  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] sample,
    input  logic                 sample_valid,
    input  logic                 adc_cs,
    input  logic                 adc_clk,
    output logic                 adc_so,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 short_frame
);

    localparam int unsigned FRAME_BITS = frame_len(DATA_BITS, LEAD_ZEROS);
    localparam int unsigned IDX_W      = idx_width(FRAME_BITS);

    logic cs_rise;
    logic cs_fall;
    logic sclk_fall;
    logic unused_sclk_rise;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (adc_cs),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (adc_clk),
        .rise    (unused_sclk_rise),
        .fall    (sclk_fall)
    );

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] load_val;
    logic [IDX_W-1:0]     idx_nxt;

    // A load coinciding with the chip-select detect goes straight into the frame.
    assign load_val = sample_valid ? sample : hold_q;
    assign idx_nxt  = idx_q + 1'b1;

    function automatic logic frame_bit(input logic [IDX_W-1:0]     i,
                                       input logic [DATA_BITS-1:0] sr);
        int unsigned          pos;
        logic [DATA_BITS-1:0] shifted;
        pos = 32'(i);
        if (pos < LEAD_ZEROS || pos >= FRAME_BITS) begin
            return 1'b0;
        end
        shifted = sr << (pos - LEAD_ZEROS);
        return shifted[DATA_BITS-1];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            shreg_q     <= '0;
            adc_so      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
            if (sample_valid) begin
                hold_q <= sample;
            end
            if (cs_rise) begin
                state_q <= IDLE;
                adc_so  <= 1'b0;
                busy    <= 1'b0;
                if (state_q == TAIL) begin
                    frame_done <= 1'b1;
                end
                if (state_q == SHIFT) begin
                    short_frame <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        // An adc_clk edge in the same cycle as the select is dropped here.
                        if (cs_fall) begin
                            shreg_q <= load_val;
                            idx_q   <= '0;
                            state_q <= SHIFT;
                            busy    <= 1'b1;
                            adc_so  <= frame_bit('0, load_val);
                        end
                    end
                    SHIFT: begin
                        if (sclk_fall) begin
                            idx_q  <= idx_nxt;
                            adc_so <= frame_bit(idx_nxt, shreg_q);
                            if (idx_nxt == IDX_W'(FRAME_BITS)) begin
                                state_q <= TAIL;
                            end
                        end
                    end
                    TAIL: begin
                        adc_so <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        adc_so  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
